// File: rtl/muldiv_seq_if.sv
// Request/result bus between the pipeline and the multiply/divide sequencer.
// The pipeline is the master: it issues ops and reads back busy/done/HI/LO.
interface muldiv_seq_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] rs_val;
   logic [WIDTH-1:0] rt_val;
   logic             busy;
   logic             done;
   logic             div_by_zero;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output start, op, rs_val, rt_val,
      input  busy, done, div_by_zero, hi, lo
   );

   modport slave (
      input  start, op, rs_val, rt_val,
      output busy, done, div_by_zero, hi, lo
   );
endinterface

// File: rtl/muldiv_seq.sv
// Bit-serial MULTU/DIVU/MTHI/MTLO sequencer owning HI/LO; iterates one shared
// external ALU per bit (shift-add multiply, compare-then-subtract restoring divide).
module muldiv_seq #(
   parameter int         WIDTH   = 32,
   parameter logic [3:0] ALU_ADD = 4'b0010,
   parameter logic [3:0] ALU_SUB = 4'b0110,
   parameter logic [3:0] ALU_SLT = 4'b0111
) (
   input  logic             clk,
   input  logic             reset,
   muldiv_seq_if.slave      bus,
   input  logic [WIDTH-1:0] alu_result,
   output logic [3:0]       alu_ctrl,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b
);
   localparam int CW = $clog2(WIDTH);
   localparam logic [1:0] OP_MULTU = 2'b00;
   localparam logic [1:0] OP_DIVU  = 2'b01;
   localparam logic [1:0] OP_MTHI  = 2'b10;
   localparam logic [1:0] OP_MTLO  = 2'b11;

   typedef enum logic [2:0] {IDLE, MUL, DIV_CMP, DIV_SUB, DONE} state_t;

   state_t           state, next_state;
   logic [WIDTH-1:0] hi, lo, mcand;
   logic [CW-1:0]    counter;
   logic             ge, div_by_zero;
   logic             accept, last, carry;
   logic [WIDTH-1:0] sh;

   assign accept = bus.start && (state == IDLE || state == DONE);
   assign last   = (counter == CW'(WIDTH - 1));
   assign sh     = {hi[WIDTH-2:0], lo[WIDTH-1]};
   // The ALU add wraps, so a result smaller than the addend means carry-out.
   assign carry  = (alu_result < hi);

   assign bus.busy        = (state == MUL) || (state == DIV_CMP) || (state == DIV_SUB);
   assign bus.done        = (state == DONE);
   assign bus.div_by_zero = div_by_zero;
   assign bus.hi          = hi;
   assign bus.lo          = lo;

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= next_state;
   end

   always_comb begin
      next_state = state;
      alu_ctrl   = ALU_ADD;
      alu_a      = '0;
      alu_b      = '0;
      case (state)
         IDLE, DONE: begin
            next_state = IDLE;
            if (accept) begin
               case (bus.op)
                  OP_MULTU: next_state = MUL;
                  OP_DIVU:  next_state = (bus.rt_val == '0) ? DONE : DIV_CMP;
                  default:  next_state = IDLE;
               endcase
            end
         end
         MUL: begin
            alu_a      = hi;
            alu_b      = lo[0] ? mcand : '0;
            next_state = last ? DONE : MUL;
         end
         DIV_CMP: begin
            alu_ctrl   = ALU_SLT;
            alu_a      = sh;
            alu_b      = mcand;
            next_state = DIV_SUB;
         end
         DIV_SUB: begin
            alu_ctrl   = ALU_SUB;
            alu_a      = sh;
            alu_b      = mcand;
            next_state = last ? DONE : DIV_CMP;
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         hi          <= '0;
         lo          <= '0;
         mcand       <= '0;
         counter     <= '0;
         ge          <= 1'b0;
         div_by_zero <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (accept) begin
                  mcand       <= bus.rt_val;
                  counter     <= '0;
                  div_by_zero <= 1'b0;
                  case (bus.op)
                     OP_MULTU: begin
                        hi <= '0;
                        lo <= bus.rs_val;
                     end
                     OP_DIVU: begin
                        if (bus.rt_val == '0) begin
                           hi          <= bus.rs_val;
                           lo          <= '1;
                           div_by_zero <= 1'b1;
                        end else begin
                           hi <= '0;
                           lo <= bus.rs_val;
                        end
                     end
                     OP_MTHI: hi <= bus.rs_val;
                     OP_MTLO: lo <= bus.rs_val;
                     default: ;
                  endcase
               end
            end
            MUL: begin
               {hi, lo} <= {carry, alu_result, lo[WIDTH-1:1]};
               counter  <= counter + CW'(1);
            end
            DIV_CMP: begin
               // A shifted-out msb means the partial remainder already exceeds any divisor.
               ge <= hi[WIDTH-1] | (alu_result == '0);
            end
            DIV_SUB: begin
               if (ge) begin
                  hi <= alu_result;
                  lo <= {lo[WIDTH-2:0], 1'b1};
               end else begin
                  hi <= sh;
                  lo <= {lo[WIDTH-2:0], 1'b0};
               end
               counter <= counter + CW'(1);
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_muldiv_seq.sv
// Randomized self-checking bench for muldiv_seq: models the external ALU and
// predicts HI/LO with plain 64-bit arithmetic.
module tb_muldiv_seq;
   localparam int         WIDTH   = 32;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_SLT = 4'b0111;
   localparam logic [1:0] OP_MULTU = 2'b00;
   localparam logic [1:0] OP_DIVU  = 2'b01;
   localparam logic [1:0] OP_MTHI  = 2'b10;
   localparam logic [1:0] OP_MTLO  = 2'b11;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic [WIDTH-1:0] alu_result;
   logic [3:0]       alu_ctrl;
   logic [WIDTH-1:0] alu_a, alu_b;
   int               checks = 0;
   int               errors = 0;
   logic [WIDTH-1:0] exp_hi = '0;
   logic [WIDTH-1:0] exp_lo = '0;

   muldiv_seq_if #(.WIDTH(WIDTH)) bus ();

   muldiv_seq #(.WIDTH(WIDTH)) dut (
      .clk        (clk),
      .reset      (reset),
      .bus        (bus.slave),
      .alu_result (alu_result),
      .alu_ctrl   (alu_ctrl),
      .alu_a      (alu_a),
      .alu_b      (alu_b)
   );

   always #5 clk = ~clk;

   // Behaviour of the shared ALU the sequencer drives.
   always_comb begin
      alu_result = '0;
      case (alu_ctrl)
         ALU_ADD: alu_result = alu_a + alu_b;
         ALU_SUB: alu_result = alu_a - alu_b;
         ALU_SLT: alu_result = {31'd0, alu_a < alu_b};
         default: alu_result = '0;
      endcase
   end

   task automatic applyStimulus(input logic [1:0] op, input logic [WIDTH-1:0] rs,
                                input logic [WIDTH-1:0] rt);
      @(negedge clk);
      bus.start  = 1'b1;
      bus.op     = op;
      bus.rs_val = rs;
      bus.rt_val = rt;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
   endtask

   // Latency counts edges from the accepting edge (inclusive) until done shows.
   task automatic run_op(input logic [1:0] op, input logic [WIDTH-1:0] rs,
                         input logic [WIDTH-1:0] rt, output int lat, output int busy_cnt);
      applyStimulus(op, rs, rt);
      lat = 1;
      busy_cnt = 0;
      while (bus.done !== 1'b1 && lat < 200) begin
         if (bus.busy === 1'b1) busy_cnt++;
         @(posedge clk);
         #1;
         lat++;
      end
      if (bus.done !== 1'b1) lat = -1;
   endtask

   task automatic check_arith(input string name, input logic [1:0] op,
                              input logic [WIDTH-1:0] rs, input logic [WIDTH-1:0] rt);
      int lat, busy_cnt, exp_lat, exp_busy;
      logic [63:0] prod;
      logic exp_dbz;
      run_op(op, rs, rt, lat, busy_cnt);
      exp_dbz = 1'b0;
      if (op == OP_MULTU) begin
         prod = 64'(rs) * 64'(rt);
         {exp_hi, exp_lo} = prod;
         exp_lat = 33; exp_busy = 32;
      end else if (rt == 0) begin
         exp_hi = rs; exp_lo = '1; exp_dbz = 1'b1;
         exp_lat = 1; exp_busy = 0;
      end else begin
         exp_lo = rs / rt; exp_hi = rs % rt;
         exp_lat = 65; exp_busy = 64;
      end
      checks++;
      if (lat !== exp_lat || busy_cnt !== exp_busy) begin
         errors++;
         $display("[TB] FAIL %s latency: got lat=%0d busy=%0d expected lat=%0d busy=%0d",
                  name, lat, busy_cnt, exp_lat, exp_busy);
      end
      checks++;
      if (bus.hi !== exp_hi || bus.lo !== exp_lo || bus.div_by_zero !== exp_dbz) begin
         errors++;
         $display("[TB] FAIL %s result: got hi=%h lo=%h dbz=%b expected hi=%h lo=%h dbz=%b (rs=%h rt=%h)",
                  name, bus.hi, bus.lo, bus.div_by_zero, exp_hi, exp_lo, exp_dbz, rs, rt);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.hi !== '0 || bus.lo !== '0 ||
          bus.div_by_zero !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_state: got busy=%b done=%b hi=%h lo=%h dbz=%b expected all zero",
                  bus.busy, bus.done, bus.hi, bus.lo, bus.div_by_zero);
      end
      checks++;
      if (alu_ctrl !== ALU_ADD || alu_a !== '0 || alu_b !== '0) begin
         errors++;
         $display("[TB] FAIL idle_alu: got ctrl=%b a=%h b=%h expected ctrl=0010 a=0 b=0",
                  alu_ctrl, alu_a, alu_b);
      end
      @(negedge clk);
      reset = 1'b0;
      exp_hi = '0; exp_lo = '0;
   endtask

   task automatic test_multu();
      check_arith("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      @(posedge clk); #1;
      checks++;
      if (bus.done !== 1'b0) begin
         errors++;
         $display("[TB] FAIL done_one_cycle: got done=%b expected 0", bus.done);
      end
      check_arith("multu_zero", OP_MULTU, 32'h0, $urandom);
      for (int i = 0; i < 4; i++) check_arith("multu_rand", OP_MULTU, $urandom, $urandom);
   endtask

   task automatic test_divu();
      check_arith("divu_100_7", OP_DIVU, 32'd100, 32'd7);
      check_arith("divu_msb", OP_DIVU, 32'hFFFF_FFFF, 32'h8000_0001);
      check_arith("divu_small", OP_DIVU, 32'd3, 32'd9);
      for (int i = 0; i < 3; i++) check_arith("divu_rand", OP_DIVU, $urandom, $urandom_range(1, 1000));
      check_arith("divu_bigdiv", OP_DIVU, $urandom, {1'b1, 31'($urandom)});
   endtask

   task automatic test_div_by_zero();
      int lat, busy_cnt;
      check_arith("divu_zero", OP_DIVU, 32'h1234_5678, 32'h0);
      applyStimulus(OP_MULTU, 32'd3, 32'd5);
      checks++;
      if (bus.div_by_zero !== 1'b0 || bus.busy !== 1'b1) begin
         errors++;
         $display("[TB] FAIL dbz_clear: got dbz=%b busy=%b expected dbz=0 busy=1",
                  bus.div_by_zero, bus.busy);
      end
      lat = 0;
      while (bus.done !== 1'b1 && lat < 100) begin @(posedge clk); #1; lat++; end
      checks++;
      if (bus.hi !== 32'd0 || bus.lo !== 32'd15 || bus.div_by_zero !== 1'b0) begin
         errors++;
         $display("[TB] FAIL multu_after_dbz: got hi=%h lo=%h dbz=%b expected hi=0 lo=f dbz=0",
                  bus.hi, bus.lo, bus.div_by_zero);
      end
      exp_hi = 32'd0; exp_lo = 32'd15;
      busy_cnt = 0;
   endtask

   task automatic test_ignore_start();
      int lat;
      applyStimulus(OP_MULTU, 32'd6, 32'd7);
      repeat (9) @(posedge clk);
      applyStimulus(OP_DIVU, 32'hDEAD_BEEF, 32'd3);
      lat = 11;
      while (bus.done !== 1'b1 && lat < 200) begin @(posedge clk); #1; lat++; end
      checks++;
      if (lat !== 33 || bus.hi !== 32'd0 || bus.lo !== 32'd42) begin
         errors++;
         $display("[TB] FAIL ignore_start: got lat=%0d hi=%h lo=%h expected lat=33 hi=0 lo=2a",
                  lat, bus.hi, bus.lo);
      end
      applyStimulus(OP_MTLO, 32'hA5, 32'd0);
      checks++;
      if (bus.lo !== 32'hA5 || bus.hi !== 32'd0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
         errors++;
         $display("[TB] FAIL mtlo_in_done: got lo=%h hi=%h busy=%b done=%b expected lo=a5 hi=0 busy=0 done=0",
                  bus.lo, bus.hi, bus.busy, bus.done);
      end
      exp_hi = 32'd0; exp_lo = 32'hA5;
   endtask

   task automatic test_alu_trace();
      int bad_div = 0, bad_mul = 0;
      logic [3:0] want;
      applyStimulus(OP_DIVU, $urandom, $urandom_range(1, 50000));
      for (int i = 0; i < 64; i++) begin
         want = (i % 2 == 0) ? ALU_SLT : ALU_SUB;
         if (alu_ctrl !== want || bus.busy !== 1'b1) bad_div++;
         @(posedge clk); #1;
      end
      checks++;
      if (bad_div != 0 || bus.done !== 1'b1) begin
         errors++;
         $display("[TB] FAIL div_alu_trace: got %0d bad cycles done=%b expected 0 bad done=1",
                  bad_div, bus.done);
      end
      applyStimulus(OP_MULTU, $urandom, $urandom);
      for (int i = 0; i < 32; i++) begin
         if (alu_ctrl !== ALU_ADD || bus.busy !== 1'b1) bad_mul++;
         @(posedge clk); #1;
      end
      checks++;
      if (bad_mul != 0 || bus.done !== 1'b1) begin
         errors++;
         $display("[TB] FAIL mul_alu_trace: got %0d bad cycles done=%b expected 0 bad done=1",
                  bad_mul, bus.done);
      end
      exp_hi = bus.hi; exp_lo = bus.lo;
   endtask

   task automatic test_reset_mid_div();
      int seen_done = 0;
      applyStimulus(OP_DIVU, $urandom, $urandom_range(1, 1000));
      repeat (19) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.hi !== '0 || bus.lo !== '0) begin
         errors++;
         $display("[TB] FAIL reset_mid_div: got busy=%b done=%b hi=%h lo=%h expected 0 0 0 0",
                  bus.busy, bus.done, bus.hi, bus.lo);
      end
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 80; i++) begin
         @(posedge clk); #1;
         if (bus.done === 1'b1 || bus.busy === 1'b1) seen_done++;
      end
      checks++;
      if (seen_done != 0) begin
         errors++;
         $display("[TB] FAIL no_done_after_reset: got %0d active cycles expected 0", seen_done);
      end
      exp_hi = '0; exp_lo = '0;
   endtask

   // Random mix issued back-to-back; each op is started in the previous DONE cycle.
   task automatic test_back_to_back();
      logic [1:0]       op;
      logic [WIDTH-1:0] rs, rt;
      for (int i = 0; i < 16; i++) begin
         op = 2'($urandom_range(0, 3));
         rs = $urandom;
         rt = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom >> $urandom_range(0, 31);
         if (op == OP_MULTU || op == OP_DIVU) begin
            check_arith("b2b_arith", op, rs, rt);
         end else begin
            applyStimulus(op, rs, rt);
            if (op == OP_MTHI) exp_hi = rs;
            else               exp_lo = rs;
            checks++;
            if (bus.hi !== exp_hi || bus.lo !== exp_lo || bus.busy !== 1'b0 ||
                bus.done !== 1'b0 || bus.div_by_zero !== 1'b0) begin
               errors++;
               $display("[TB] FAIL b2b_move: got hi=%h lo=%h busy=%b done=%b dbz=%b expected hi=%h lo=%h 0 0 0",
                        bus.hi, bus.lo, bus.busy, bus.done, bus.div_by_zero, exp_hi, exp_lo);
            end
         end
      end
   endtask

   initial begin
      bus.start  = 1'b0;
      bus.op     = 2'b00;
      bus.rs_val = '0;
      bus.rt_val = '0;
      test_reset();
      test_multu();
      test_divu();
      test_div_by_zero();
      test_ignore_start();
      test_alu_trace();
      test_reset_mid_div();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
